// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-generic ALU with iterative shifts and valid/ready handshake.
// Optional shift-add multiplier on opcode 0111 when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_enable,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flag_out,
    output logic             out_valid
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0111;
`endif

    localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef ALU_MUL_EN
        ,
        MUL   = 2'd2
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] work_q;
    logic             left_q;
    logic             ovr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] out_q;
    logic [3:0]       flag_q;
    logic             valid_q;

    logic             accept;
    logic             shift_req;
    logic [CNT_W-1:0] n_shift;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;

    logic [WIDTH-1:0] sh_nxt;
    logic             sh_bit;

    logic             res_load;
    logic [WIDTH-1:0] res_val;
    logic             res_c;
    logic             res_f0;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     mul_sum;
    logic               mul_req;
`endif

    assign in_ready  = (state_q == IDLE);
    assign accept    = start & in_ready & alu_enable;
    assign shift_req = ((opcode == OP_SHL) || (opcode == OP_SHR))
                     && (b != '0);
    assign n_shift   = (b > W_VAL) ? N_MAX : CNT_W'(b);

    assign out       = out_q;
    assign flag_out  = flag_q;
    assign out_valid = valid_q;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        unique case (opcode)
            OP_ADD:         {sc_c, sc_res} = sum;
            OP_SUB:         {sc_c, sc_res} = diff;
            OP_AND:         sc_res = a & b;
            OP_OR:          sc_res = a | b;
            OP_XOR:         sc_res = a ^ b;
            OP_SHL, OP_SHR: sc_res = a;
            default:        sc_res = '0;
        endcase
    end

    // One logical shift step; sh_bit is the bit leaving the register.
    assign sh_nxt = left_q ? {work_q[WIDTH-2:0], 1'b0}
                           : {1'b0, work_q[WIDTH-1:1]};
    assign sh_bit = left_q ? work_q[WIDTH-1] : work_q[0];

`ifdef ALU_MUL_EN
    // Right-shifting product register: high half accumulates, low half holds b.
    assign mul_req  = (opcode == OP_MUL);
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, work_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d  = state_q;
        res_load = 1'b0;
        res_val  = '0;
        res_c    = 1'b0;
        res_f0   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (shift_req) begin
                        state_d = SHIFT;
                    end
`ifdef ALU_MUL_EN
                    else if (mul_req) begin
                        state_d = MUL;
                    end
`endif
                    else begin
                        res_load = 1'b1;
                        res_val  = sc_res;
                        res_c    = sc_c;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    res_load = 1'b1;
                    res_val  = ovr_q ? '0 : sh_nxt;
                    res_f0   = ~ovr_q & sh_bit;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (cnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    res_load = 1'b1;
                    res_val  = prod_nxt[WIDTH-1:0];
                    res_c    = |prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (alu_enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flag_q  <= '0;
            valid_q <= 1'b0;
        end else if (alu_enable) begin
            valid_q <= res_load;
            if (res_load) begin
                out_q  <= res_val;
                flag_q <= {res_c, res_val[WIDTH-1],
                           res_val == '0, res_f0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            left_q <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
`ifdef ALU_MUL_EN
            prod_q <= '0;
`endif
        end else if (alu_enable) begin
            if (accept) begin
                work_q <= a;
                left_q <= (opcode == OP_SHL);
                ovr_q  <= (b > W_VAL);
                cnt_q  <= n_shift;
`ifdef ALU_MUL_EN
                prod_q <= {{WIDTH{1'b0}}, b};
                if (mul_req) begin
                    cnt_q <= N_MAX;
                end
`endif
            end else if (state_q == SHIFT) begin
                work_q <= sh_nxt;
                cnt_q  <= cnt_q - CNT_ONE;
            end
`ifdef ALU_MUL_EN
            else if (state_q == MUL) begin
                prod_q <= prod_nxt;
                cnt_q  <= cnt_q - CNT_ONE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
// Build with or without ALU_MUL_EN; the model follows the same macro.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         alu_enable;
    logic         start;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic [W-1:0] out;
    logic [3:0]   flag_out;
    logic         out_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_enable (alu_enable),
        .start      (start),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out        (out),
        .flag_out   (flag_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] op,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] r,
                                  output logic [3:0] f,
                                  output int lat);
        int ai;
        int bi;
        int full;
        logic c;
        logic f0;
        ai  = int'(x);
        bi  = int'(y);
        c   = 1'b0;
        f0  = 1'b0;
        lat = 1;
        r   = '0;
        case (op)
            4'd0: begin
                full = ai + bi;
                r = W'(full);
                c = (full >= (1 << W));
            end
            4'd1: begin
                r = W'(ai - bi);
                c = (ai < bi);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd6: r = x ^ y;
            4'd4, 4'd5: begin
                if (bi == 0) begin
                    r = x;
                end else begin
                    lat = ((bi < W) ? bi : W) + 1;
                    if (bi < W)
                        r = (op == 4'd4) ? W'(ai << bi) : W'(ai >> bi);
                    if (bi <= W)
                        f0 = (op == 4'd4) ? ((ai >> (W - bi)) & 1) != 0
                                          : ((ai >> (bi - 1)) & 1) != 0;
                end
            end
`ifdef ALU_MUL_EN
            4'd7: begin
                full = ai * bi;
                r = W'(full);
                c = (full >= (1 << W));
                lat = W + 1;
            end
`endif
            default: r = '0;
        endcase
        f = {c, r[W-1], r == '0, f0};
    endfunction

    // Issues one op, returns the result and cycles to out_valid (-1 on timeout).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] r,
                          output logic [3:0] f, output int lat);
        @(negedge clk);
        start = 1'b1;
        opcode = op;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        r = out;
        f = flag_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out, flag_out, out_valid, in_ready} !== {{W{1'b0}}, 4'b0, 1'b0, 1'b1})
            $display("FAIL reset: out=%h flag=%b v=%b rdy=%b, want 00 0000 0 1",
                     out, flag_out, out_valid, in_ready);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [3:0]   f;
        logic [7:0]   lat;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[$];
        logic [W-1:0] r;
        logic [3:0] f;
        int lat;
        tbl.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010, 8'd1});
        tbl.push_back('{4'h0, 8'h7F, 8'h01, 8'h80, 4'b0100, 8'd1});
        tbl.push_back('{4'h1, 8'h10, 8'h20, 8'hF0, 4'b1100, 8'd1});
        tbl.push_back('{4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 8'd1});
        tbl.push_back('{4'h3, 8'h00, 8'h00, 8'h00, 4'b0010, 8'd1});
        tbl.push_back('{4'h6, 8'hAA, 8'h55, 8'hFF, 4'b0100, 8'd1});
        tbl.push_back('{4'h4, 8'h81, 8'h01, 8'h02, 4'b0001, 8'd2});
        tbl.push_back('{4'h5, 8'h81, 8'h03, 8'h10, 4'b0000, 8'd4});
        tbl.push_back('{4'h4, 8'h5A, 8'h09, 8'h00, 4'b0010, 8'd9});
        tbl.push_back('{4'h4, 8'h5A, 8'h00, 8'h5A, 4'b0000, 8'd1});
        tbl.push_back('{4'h5, 8'h81, 8'h08, 8'h00, 4'b0011, 8'd9});
        tbl.push_back('{4'hF, 8'h12, 8'h34, 8'h00, 4'b0010, 8'd1});
`ifdef ALU_MUL_EN
        tbl.push_back('{4'h7, 8'h10, 8'h10, 8'h00, 4'b1010, 8'd9});
        tbl.push_back('{4'h7, 8'h0F, 8'h0F, 8'hE1, 4'b0100, 8'd9});
`else
        tbl.push_back('{4'h7, 8'h10, 8'h10, 8'h00, 4'b0010, 8'd1});
`endif
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].x, tbl[i].y, r, f, lat);
            total_cnt++;
            if (r !== tbl[i].r || f !== tbl[i].f || lat != int'(tbl[i].lat))
                $display("FAIL directed[%0d] op=%h: out=%h flag=%b lat=%0d, want %h %b %0d",
                         i, tbl[i].op, r, f, lat, tbl[i].r, tbl[i].f, tbl[i].lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] x, y, r, er;
        logic [3:0] f, ef;
        int lat, el;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
            model(op, x, y, er, ef, el);
            run_op(op, x, y, r, f, lat);
            total_cnt++;
            if (r !== er || f !== ef || lat != el)
                $display("FAIL random op=%h a=%h b=%h: out=%h flag=%b lat=%0d, want %h %b %0d",
                         op, x, y, r, f, lat, er, ef, el);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[3] = '{4'h0, 4'h1, 4'h6};
        logic [W-1:0] xs[3] = '{8'h12, 8'h05, 8'hC3};
        logic [W-1:0] ys[3] = '{8'h34, 8'h07, 8'h3C};
        logic [W-1:0] er;
        logic [3:0] ef;
        int el;
        @(negedge clk);
        start = 1'b1;
        opcode = ops[0];
        a = xs[0];
        b = ys[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model(ops[i], xs[i], ys[i], er, ef, el);
            total_cnt++;
            if (out_valid !== 1'b1 || out !== er || flag_out !== ef)
                $display("FAIL b2b[%0d]: v=%b out=%h flag=%b, want 1 %h %b",
                         i, out_valid, out, flag_out, er, ef);
            else pass_cnt++;
            if (i < 2) begin
                opcode = ops[i+1];
                a = xs[i+1];
                b = ys[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_end: out_valid=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_start_held();
        logic [W-1:0] x, er;
        logic [3:0] ef;
        int el, lat, busy_bad;
        x = W'($urandom);
        model(4'h4, x, 8'd5, er, ef, el);
        @(negedge clk);
        start = 1'b1;
        opcode = 4'h4;
        a = x;
        b = 8'd5;
        @(negedge clk);
        opcode = 4'h0;
        a = 8'h01;
        b = 8'h01;
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!out_valid) lat = -1;
        total_cnt++;
        if (busy_bad != 0)
            $display("FAIL start_held_ready: in_ready high %0d busy cycles, want 0", busy_bad);
        else pass_cnt++;
        total_cnt++;
        if (out !== er || flag_out !== ef || lat != el)
            $display("FAIL start_held: out=%h flag=%b lat=%0d, want %h %b %0d",
                     out, flag_out, lat, er, ef, el);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL start_held_extra: out_valid=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [W-1:0] x, er, held;
        logic [3:0] ef;
        int el, lat;
        x = W'($urandom);
        model(4'h4, x, 8'd5, er, ef, el);
        @(negedge clk);
        start = 1'b1;
        opcode = 4'h4;
        a = x;
        b = 8'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat == 2) alu_enable = 1'b0;
            if (lat == 5) alu_enable = 1'b1;
            @(negedge clk);
            lat++;
        end
        alu_enable = 1'b1;
        if (!out_valid) lat = -1;
        total_cnt++;
        if (out !== er || flag_out !== ef || lat != el + 3)
            $display("FAIL stall_shift: out=%h flag=%b lat=%0d, want %h %b %0d",
                     out, flag_out, lat, er, ef, el + 3);
        else pass_cnt++;
        // A pending out_valid must persist across disabled edges.
        @(negedge clk);
        start = 1'b1;
        opcode = 4'h0;
        a = 8'h21;
        b = 8'h12;
        @(negedge clk);
        start = 1'b0;
        alu_enable = 1'b0;
        held = out;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out !== 8'h33 || held !== 8'h33)
            $display("FAIL stall_hold: v=%b out=%h, want 1 33", out_valid, out);
        else pass_cnt++;
        alu_enable = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL stall_release: out_valid=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        logic [3:0] f;
        int lat, seen;
        run_op(4'h3, 8'h5A, 8'h00, r, f, lat);
        @(negedge clk);
        start = 1'b1;
        opcode = 4'h5;
        a = 8'hF0;
        b = 8'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out, flag_out, out_valid, in_ready} !== {8'h00, 4'b0, 1'b0, 1'b1})
            $display("FAIL reset_mid: out=%h flag=%b v=%b rdy=%b, want 00 0000 0 1",
                     out, flag_out, out_valid, in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0)
            $display("FAIL reset_mid_valid: %0d stray pulses, want 0", seen);
        else pass_cnt++;
        run_op(4'h0, 8'h02, 8'h03, r, f, lat);
        total_cnt++;
        if (r !== 8'h05 || f !== 4'b0000 || lat != 1)
            $display("FAIL reset_mid_next: out=%h flag=%b lat=%0d, want 05 0000 1",
                     r, f, lat);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_enable = 1'b1;
        start = 1'b0;
        opcode = '0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_held();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
